// File: rtl/mips_bus_stall_ram.sv
// mips_bus_stall_ram
//   Avalon-style memory-mapped slave for the mips_cpu_bus memory port.
//   Two word-addressed windows: a boot window at 0xBFC00000 (RESET_WORDS
//   deep) and a data window at 0x00000000 (DATA_WORDS deep). Every transfer
//   holds waitrequest high for N+1 cycles, where N is 0, FIXED_WAIT or a
//   3-bit LFSR sample depending on STALL_MODE. Master misbehaviour sets a
//   sticky protocol_error flag that only reset clears.
// Ports:
//   clk            rising-edge clock
//   reset          synchronous active-high reset (memory contents kept)
//   address        byte address, bits [1:0] ignored
//   write, read    transfer requests
//   waitrequest    high while the slave is not ready to complete
//   writedata      write data
//   byteenable     write lane enables, bit0 = writedata[7:0]
//   readdata       read data, valid when read=1 and waitrequest=0
//   protocol_error sticky violation flag
module mips_bus_stall_ram #(
  parameter string      INIT_FILE      = "",
  parameter string      DATA_INIT_FILE = "",
  parameter int         RESET_WORDS    = 256,
  parameter int         DATA_WORDS     = 1024,
  parameter int         STALL_MODE     = 0,
  parameter int         FIXED_WAIT     = 3,
  parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        write,
  input  logic        read,
  output logic        waitrequest,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        protocol_error
);

  localparam logic [29:0] RESET_BASE = 30'h2FF0_0000;  // 0xBFC00000 >> 2
  localparam int RA_W = (RESET_WORDS > 1) ? $clog2(RESET_WORDS) : 1;
  localparam int DA_W = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  // 8-bit Fibonacci LFSR step, taps 8,6,5,4
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  logic [31:0] reset_mem [RESET_WORDS];
  logic [31:0] data_mem  [DATA_WORDS];

  state_t      state_r, next_state_s;
  logic [7:0]  cnt_r;
  logic [29:0] addr_r;
  logic        is_write_r;
  logic [31:0] wdata_r;
  logic [3:0]  be_r;
  logic [7:0]  lfsr_r;

  logic [29:0] cur_word_s;
  logic [29:0] roff_s;
  logic        hit_reset_s, hit_data_s;
  logic [31:0] rd_word_s;
  logic [7:0]  n_load_s;
  logic        req_s, accept_s, load_rd_s, commit_s, set_err_s;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^address[1:0];
  assign req_s = read | write;

  // In IDLE the live bus address is decoded (acceptance cycle); afterwards the latched one
  assign cur_word_s  = (state_r == IDLE) ? address[31:2] : addr_r;
  assign roff_s      = cur_word_s - RESET_BASE;
  assign hit_reset_s = (cur_word_s >= RESET_BASE) && (roff_s < 30'(RESET_WORDS));
  assign hit_data_s  = (cur_word_s < 30'(DATA_WORDS));

  // Array read of the decoded word; out-of-window reads yield zero
  always_comb begin
    rd_word_s = 32'd0;
    if (hit_reset_s) begin
      rd_word_s = reset_mem[roff_s[RA_W-1:0]];
    end else if (hit_data_s) begin
      rd_word_s = data_mem[cur_word_s[DA_W-1:0]];
    end else begin
      rd_word_s = 32'd0;
    end
  end

  // Stall length chosen at acceptance
  always_comb begin
    n_load_s = 8'd0;
    case (STALL_MODE)
      1:       n_load_s = 8'(FIXED_WAIT);
      2:       n_load_s = {5'd0, lfsr_r[2:0]};
      default: n_load_s = 8'd0;
    endcase
  end

  // Handshake FSM: next state, waitrequest and per-cycle strobes
  always_comb begin
    next_state_s = state_r;
    waitrequest  = 1'b0;
    accept_s     = 1'b0;
    load_rd_s    = 1'b0;
    commit_s     = 1'b0;
    set_err_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          waitrequest  = 1'b1;
          accept_s     = 1'b1;
          next_state_s = (n_load_s != 8'd0) ? WAIT : RESP;
          // Zero stall goes straight to RESP, so capture read data now
          load_rd_s    = (n_load_s == 8'd0) && read;
          set_err_s    = (read && write) || !(hit_reset_s || hit_data_s) ||
                         (write && !read && (byteenable == 4'd0));
        end else begin
          next_state_s = IDLE;
        end
      end
      WAIT: begin
        waitrequest = 1'b1;
        // Master gave up the request it started: abort without commit
        if (is_write_r ? !write : !read) begin
          next_state_s = IDLE;
          set_err_s    = 1'b1;
        end else begin
          set_err_s = (address[31:2] != addr_r);
          if (cnt_r == 8'd1) begin
            next_state_s = RESP;
            load_rd_s    = !is_write_r;
          end else begin
            next_state_s = WAIT;
          end
        end
      end
      RESP: begin
        next_state_s = IDLE;
        commit_s     = is_write_r && (hit_reset_s || hit_data_s);
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Control registers, read data and the sticky error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      cnt_r          <= 8'd0;
      addr_r         <= 30'd0;
      is_write_r     <= 1'b0;
      wdata_r        <= 32'd0;
      be_r           <= 4'd0;
      lfsr_r         <= LFSR_SEED;
      readdata       <= 32'd0;
      protocol_error <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (set_err_s) protocol_error <= 1'b1;
      if (load_rd_s) readdata <= rd_word_s;
      if (accept_s) begin
        lfsr_r     <= lfsr_step(lfsr_r);
        cnt_r      <= n_load_s;
        addr_r     <= address[31:2];
        is_write_r <= write && !read;  // read+write collapses to a read
        wdata_r    <= writedata;
        be_r       <= byteenable;
      end else if (state_r == WAIT) begin
        cnt_r <= cnt_r - 8'd1;
      end
    end
  end

  // Commit enabled byte lanes at the edge that ends RESP
  always_ff @(posedge clk) begin
    if (!reset && commit_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_r[i]) begin
          if (hit_reset_s) reset_mem[roff_s[RA_W-1:0]][8*i +: 8] <= wdata_r[8*i +: 8];
          else data_mem[cur_word_s[DA_W-1:0]][8*i +: 8] <= wdata_r[8*i +: 8];
        end
      end
    end
  end

endmodule
